sc_port_router: RTL and testbench
=================================

SC_PORT_ROUTER -- requirements
Module: sc_port_router

Interface
REQ-001 The block SHALL have parameter NPORTS, default 4, number of downstream slow-control slaves (1..8).
REQ-002 The block SHALL have parameter PORT_LIST, default {16'h1797,16'h1978,16'h1977,16'h1877}, NPORTS*16 bits, where slice i is the UDP port of slave i.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 4096, the maximum number of clk cycles to wait for a slave ack (2..65535).
REQ-004 clk  input  1  system clock; every register updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 sc_port  input  16  destination port of the current transaction.
REQ-007 sc_frame  input  1  master transaction frame.
REQ-008 sc_ack  output  1  acknowledge to the master.
REQ-009 sc_rply_data  output  32  reply data to the master.
REQ-010 sc_rply_error  output  32  reply error word to the master.
REQ-011 s_frame  output  NPORTS  per-slave gated frame.
REQ-012 s_ack  input  NPORTS  per-slave acknowledge.
REQ-013 s_rply_data  input  NPORTS*32  per-slave reply data, slice i belonging to slave i.
REQ-014 s_rply_error  input  NPORTS*32  per-slave reply error word, slice i belonging to slave i.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 timeout_cnt  output  16  saturating count of timed-out transactions.
REQ-017 unmapped_cnt  output  16  saturating count of transactions addressed to an unmapped port.
REQ-018 sc_data, sc_addr, sc_subaddr, sc_op and sc_wr SHALL be routed to the slaves outside this block; they are not ports of this block.

Function
REQ-019 The state machine SHALL have four states: IDLE, FWD, UNMAP and TOUT.
REQ-020 In IDLE, when sc_frame=1, the block SHALL compare sc_port against every PORT_LIST entry; if several entries match, the lowest index wins.
REQ-021 On a match in IDLE, the block SHALL latch the matched index (sel) and go to FWD; s_frame[sel] SHALL go high on the same edge, i.e. one cycle after sc_frame was sampled.
REQ-022 With no match in IDLE, the block SHALL go to UNMAP and increment unmapped_cnt; the count saturates at 16'hFFFF.
REQ-023 sel and the routing decision SHALL be fixed for the whole transaction; changes on sc_port after IDLE SHALL be ignored.
REQ-024 In FWD, s_frame[sel] SHALL equal the registered value of sc_frame, and every other s_frame bit SHALL be 0.
REQ-025 In FWD, sc_ack SHALL equal s_ack[sel] registered, i.e. it follows with 1 cycle of latency.
REQ-026 In FWD, sc_rply_data and sc_rply_error SHALL be loaded from slice sel on every cycle where s_ack[sel]=1, and SHALL hold their values otherwise.
REQ-027 FWD SHALL return to IDLE when the registered sc_frame=0 and s_ack[sel]=0; sc_ack SHALL be 0 on that edge.
REQ-028 The timeout counter SHALL clear on entry to FWD and increment each cycle while s_ack[sel] has never been seen in the current transaction.
REQ-029 When the timeout counter reaches TIMEOUT_CYC with no ack seen, the block SHALL go to TOUT, drive s_frame to all zeros, increment timeout_cnt (saturating), set sc_rply_data=0 and set sc_rply_error=32'hFFFFFFFE.
REQ-030 Once s_ack[sel] has been seen, the timeout SHALL be disabled for the rest of that transaction.
REQ-031 In UNMAP, the block SHALL set sc_rply_data=0 and sc_rply_error=32'hFFFFFFFF.
REQ-032 In UNMAP and in TOUT, sc_ack SHALL equal sc_frame registered; the state SHALL return to IDLE when the registered sc_frame=0.
REQ-033 On return to IDLE from TOUT, a late s_ack from the abandoned slave SHALL be ignored.
REQ-034 A new transaction SHALL NOT start until the previous one is back in IDLE, so the minimum gap between transactions is 1 cycle of sc_frame=0 seen in IDLE.
REQ-035 If s_ack[sel] and the timeout terminal count occur on the same cycle, the ack SHALL win and the state SHALL stay FWD.
REQ-036 s_ack bits other than s_ack[sel] SHALL be ignored.
REQ-037 The timeout counter width SHALL be $clog2(TIMEOUT_CYC+1).
REQ-038 sel width SHALL be max(1,$clog2(NPORTS)).

Reset
REQ-039 On rst=1, the state SHALL be IDLE, and sc_ack=0, s_frame=0, busy=0, sc_rply_data=0 and sc_rply_error=0.
REQ-040 On rst=1, timeout_cnt and unmapped_cnt SHALL be 0, and the timeout counter SHALL be 0.
REQ-041 A reset asserted mid-transaction SHALL abort the transaction within 1 cycle and drop every s_frame bit, with no error counted.

Verification
REQ-042 The bench SHALL cover: port 16'h1977, slave 2 acks 5 cycles later with data 32'h12345678, error 0 -> s_frame=4'b0100 one cycle after sc_frame, sc_ack one cycle after s_ack[2], reply 32'h12345678/0.
REQ-043 The bench SHALL cover: port 16'h1234 -> no s_frame, sc_ack follows frame, error 32'hFFFFFFFF, data 0, unmapped_cnt=1.
REQ-044 The bench SHALL cover: port 16'h1877 with TIMEOUT_CYC=16 and slave 0 never acking -> s_frame[0] drops after 16 cycles, error 32'hFFFFFFFE, timeout_cnt=1, and a late s_ack[0] has no effect.
REQ-045 The bench SHALL cover: sc_port switched from 16'h1877 to 16'h1797 two cycles into a frame -> the transaction stays on slave 0 and s_frame[3] stays 0.
REQ-046 The bench SHALL cover: rst=1 during FWD with s_frame[1]=1 -> s_frame=0, state IDLE and counters 0 on the next cycle.
REQ-047 The bench SHALL cover: PORT_LIST with entries 1 and 3 both 16'h1978 -> slave 1 is selected and s_frame=4'b0010.

Source files
------------

// File: rtl/sc_port_router.sv
// Slow-control port router: steers one master transaction to the slave whose
// UDP port matches, and answers unmapped or silent-slave transactions itself.
module sc_port_router #(
  parameter int                   NPORTS      = 4,
  parameter logic [NPORTS*16-1:0] PORT_LIST   = {16'h1797, 16'h1978, 16'h1977, 16'h1877},
  parameter int                   TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            sc_port,
  input  logic                   sc_frame,
  output logic                   sc_ack,
  output logic [31:0]            sc_rply_data,
  output logic [31:0]            sc_rply_error,
  output logic [NPORTS-1:0]      s_frame,
  input  logic [NPORTS-1:0]      s_ack,
  input  logic [NPORTS*32-1:0]   s_rply_data,
  input  logic [NPORTS*32-1:0]   s_rply_error,
  output logic                   busy,
  output logic [15:0]            timeout_cnt,
  output logic [15:0]            unmapped_cnt
);

  localparam int SW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, FWD, UNMAP, TOUT} state_t;

  state_t            state;
  logic [SW-1:0]     sel;
  logic [TW-1:0]     tcnt;
  logic              ack_seen;

  logic              hit;
  logic [SW-1:0]     hit_idx;
  logic [NPORTS-1:0] hit_mask;
  logic [NPORTS-1:0] sel_mask;
  logic              sel_ack;
  logic [31:0]       sel_data;
  logic [31:0]       sel_err;

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (sc_port == PORT_LIST[i*16 +: 16]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign hit_mask = NPORTS'(1) << hit_idx;
  assign sel_mask = NPORTS'(1) << sel;
  assign sel_ack  = s_ack[sel];
  assign sel_data = s_rply_data[sel*32 +: 32];
  assign sel_err  = s_rply_error[sel*32 +: 32];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= '0;
      tcnt          <= '0;
      ack_seen      <= 1'b0;
      sc_ack        <= 1'b0;
      s_frame       <= '0;
      sc_rply_data  <= '0;
      sc_rply_error <= '0;
      timeout_cnt   <= '0;
      unmapped_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          sc_ack  <= 1'b0;
          s_frame <= '0;
          if (sc_frame) begin
            if (hit) begin
              state    <= FWD;
              sel      <= hit_idx;
              s_frame  <= hit_mask;
              tcnt     <= '0;
              ack_seen <= 1'b0;
            end else begin
              state         <= UNMAP;
              sc_ack        <= 1'b1;
              sc_rply_data  <= '0;
              sc_rply_error <= 32'hFFFF_FFFF;
              if (unmapped_cnt != 16'hFFFF) unmapped_cnt <= unmapped_cnt + 16'd1;
            end
          end
        end

        FWD: begin
          sc_ack  <= sel_ack;
          s_frame <= sc_frame ? sel_mask : '0;
          if (sel_ack) begin
            sc_rply_data  <= sel_data;
            sc_rply_error <= sel_err;
            ack_seen      <= 1'b1;
          end
          // An ack on the terminal-count cycle keeps the transaction alive.
          if (!sc_frame && !sel_ack) begin
            state <= IDLE;
          end else if (!ack_seen && !sel_ack) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TLAST) begin
              state         <= TOUT;
              s_frame       <= '0;
              sc_ack        <= sc_frame;
              sc_rply_data  <= '0;
              sc_rply_error <= 32'hFFFF_FFFE;
              if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
            end
          end
        end

        UNMAP, TOUT: begin
          sc_ack  <= sc_frame;
          s_frame <= '0;
          if (!sc_frame) state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          sc_ack  <= 1'b0;
          s_frame <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_port_router.sv
// Randomized bench for sc_port_router: each transaction's expected outputs are
// derived cycle by cycle from its timeline (frame length, ack cycles, timeout).
module tb_sc_port_router;

  localparam int NP = 4;
  localparam int T  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       sc_port;
  logic              sc_frame;
  logic              sc_ack;
  logic [31:0]       sc_rply_data;
  logic [31:0]       sc_rply_error;
  logic [NP-1:0]     s_frame;
  logic [NP-1:0]     s_ack;
  logic [NP*32-1:0]  s_rply_data;
  logic [NP*32-1:0]  s_rply_error;
  logic              busy;
  logic [15:0]       timeout_cnt;
  logic [15:0]       unmapped_cnt;

  logic              dup_sc_ack;
  logic [31:0]       dup_sc_rply_data;
  logic [31:0]       dup_sc_rply_error;
  logic [NP-1:0]     dup_s_frame;
  logic              dup_busy;
  logic [15:0]       dup_timeout_cnt;
  logic [15:0]       dup_unmapped_cnt;

  // Slave 2 answers 16'h1977 here so the directed transactions line up.
  sc_port_router #(
    .NPORTS(NP),
    .PORT_LIST({16'h1797, 16'h1977, 16'h1978, 16'h1877}),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst), .sc_port(sc_port), .sc_frame(sc_frame),
    .sc_ack(sc_ack), .sc_rply_data(sc_rply_data), .sc_rply_error(sc_rply_error),
    .s_frame(s_frame), .s_ack(s_ack), .s_rply_data(s_rply_data),
    .s_rply_error(s_rply_error), .busy(busy), .timeout_cnt(timeout_cnt),
    .unmapped_cnt(unmapped_cnt)
  );

  // Second instance with a duplicated entry to exercise lowest-index priority.
  sc_port_router #(
    .NPORTS(NP),
    .PORT_LIST({16'h1978, 16'h1977, 16'h1978, 16'h1877}),
    .TIMEOUT_CYC(T)
  ) dut_dup (
    .clk(clk), .rst(rst), .sc_port(sc_port), .sc_frame(sc_frame),
    .sc_ack(dup_sc_ack), .sc_rply_data(dup_sc_rply_data),
    .sc_rply_error(dup_sc_rply_error), .s_frame(dup_s_frame), .s_ack(s_ack),
    .s_rply_data(s_rply_data), .s_rply_error(s_rply_error), .busy(dup_busy),
    .timeout_cnt(dup_timeout_cnt), .unmapped_cnt(dup_unmapped_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] portMap [NP] = '{16'h1877, 16'h1978, 16'h1977, 16'h1797};
  logic [15:0] dupMap  [NP] = '{16'h1877, 16'h1978, 16'h1977, 16'h1978};

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] expData;
  logic [31:0] expErr;
  logic [15:0] expUnmap;
  logic [15:0] expTout;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  function automatic int lookupPort(input logic [15:0] p, input bit useDup);
    for (int i = 0; i < NP; i++) begin
      if ((useDup ? dupMap[i] : portMap[i]) == p) return i;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic frame, input logic [15:0] port, input logic [NP-1:0] ack,
                               input int loadIdx, input logic [31:0] d, input logic [31:0] e);
    sc_frame = frame;
    sc_port  = port;
    s_ack    = ack;
    for (int i = 0; i < NP; i++) begin
      s_rply_data[i*32 +: 32]  = $urandom;
      s_rply_error[i*32 +: 32] = $urandom;
    end
    if (loadIdx >= 0) begin
      s_rply_data[loadIdx*32 +: 32]  = d;
      s_rply_error[loadIdx*32 +: 32] = e;
    end
  endtask

  task automatic checkCycle(input logic [NP-1:0] ef, input logic ea, input logic eb);
    checkOutput("s_frame", 32'(s_frame), 32'(ef));
    checkOutput("sc_ack", 32'(sc_ack), 32'(ea));
    checkOutput("busy", 32'(busy), 32'(eb));
    checkOutput("sc_rply_data", sc_rply_data, expData);
    checkOutput("sc_rply_error", sc_rply_error, expErr);
    checkOutput("timeout_cnt", 32'(timeout_cnt), 32'(expTout));
    checkOutput("unmapped_cnt", 32'(unmapped_cnt), 32'(expUnmap));
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 16'($urandom), NP'($urandom), -1, 32'h0, 32'h0);
      @(negedge clk);
      checkCycle('0, 1'b0, 1'b0);
    end
  endtask

  // ackAt = 0 on a mapped port means the slave stays silent until after the timeout.
  task automatic runTxn(input logic [15:0] port, input logic [15:0] port2, input int ackAt,
                        input int frameLen, input logic [31:0] d, input logic [31:0] e);
    int            sel;
    int            dsel;
    bit            timeoutTxn;
    bit            frame;
    bit            ackSel;
    bit            tout;
    logic [NP-1:0] noise;
    logic [NP-1:0] ef;
    logic          ea;
    sel        = lookupPort(port, 1'b0);
    dsel       = lookupPort(port, 1'b1);
    timeoutTxn = (sel >= 0) && (ackAt == 0);
    for (int c = 0; c <= frameLen + 2; c++) begin
      frame = (c < frameLen);
      if (sel < 0)         ackSel = 1'b0;
      else if (timeoutTxn) ackSel = (c > T);
      else                 ackSel = frame && (c == ackAt || c == frameLen - 1);
      noise = NP'($urandom);
      if (sel >= 0) noise[sel] = ackSel;
      applyStimulus(frame, (c < 2) ? port : port2, noise, ackSel ? sel : -1, d, e);
      @(negedge clk);
      tout = timeoutTxn && (c >= T);
      if (sel < 0 && c == 0) begin
        expData = 32'h0;
        expErr  = 32'hFFFF_FFFF;
        if (expUnmap != 16'hFFFF) expUnmap++;
      end
      if (timeoutTxn && c == T) begin
        expData = 32'h0;
        expErr  = 32'hFFFF_FFFE;
        if (expTout != 16'hFFFF) expTout++;
      end
      if (!timeoutTxn && sel >= 0 && ackSel) begin
        expData = d;
        expErr  = e;
      end
      ef = (sel >= 0 && !tout && frame) ? NP'(1 << sel) : '0;
      ea = (sel < 0 || tout) ? frame : (c >= 1 && ackSel);
      checkCycle(ef, ea, frame);
      if (c == 0) checkOutput("dup_s_frame", 32'(dup_s_frame), (dsel >= 0) ? 32'(1 << dsel) : 32'h0);
    end
  endtask

  initial begin
    int k;
    int a;
    logic [15:0] port;
    expData  = 32'h0;
    expErr   = 32'h0;
    expUnmap = 16'h0;
    expTout  = 16'h0;

    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, '0, -1, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkCycle('0, 1'b0, 1'b0);
    rst = 1'b0;
    idleCycles(2);

    runTxn(16'h1977, 16'h1977, 5, 6, 32'h1234_5678, 32'h0);
    idleCycles(2);
    runTxn(16'h1234, 16'h1234, 0, 3, 32'h0, 32'h0);
    idleCycles(1);
    runTxn(16'h1877, 16'h1877, 0, T + 3, 32'h0, 32'h0);
    idleCycles(2);
    runTxn(16'h1877, 16'h1797, 4, 6, $urandom, $urandom);
    idleCycles(1);
    runTxn(16'h1978, 16'h1978, 3, 5, $urandom, $urandom);
    idleCycles(1);
    runTxn(16'h1797, 16'($urandom), T, T + 2, $urandom, $urandom);
    idleCycles(1);

    // Reset in the middle of a forwarded transaction to slave 1.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 16'h1978, '0, -1, 32'h0, 32'h0);
      @(negedge clk);
      checkCycle(4'b0010, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 16'h1978, '0, -1, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    expData  = 32'h0;
    expErr   = 32'h0;
    expUnmap = 16'h0;
    expTout  = 16'h0;
    checkCycle('0, 1'b0, 1'b0);
    rst = 1'b0;
    idleCycles(2);

    for (int n = 0; n < 40; n++) begin
      k    = int'($urandom_range(0, 4));
      port = (k < 4) ? portMap[k] : {4'h2, 12'($urandom)};
      if (k == 4) begin
        runTxn(port, 16'($urandom), 0, int'($urandom_range(1, 5)), 32'h0, 32'h0);
      end else if ($urandom_range(0, 3) == 0) begin
        runTxn(port, 16'($urandom), 0, T + int'($urandom_range(1, 4)), 32'h0, 32'h0);
      end else begin
        a = int'($urandom_range(1, T));
        runTxn(port, 16'($urandom), a, a + 1 + int'($urandom_range(0, 6)), $urandom, $urandom);
      end
      idleCycles(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
